// File: rtl/tile_pattern_pkg.sv
// tile_pattern_pkg: shared encodings and constants for the tile
// pattern generator and its random palette source.
package tile_pattern_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_CHECKER = 2'd0;
    localparam mode_t MODE_BOX     = 2'd1;
    localparam mode_t MODE_XOR     = 2'd2;
    localparam mode_t MODE_BARS    = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    localparam logic [15:0] DEF_SEED = 16'hACE1;
    localparam logic [15:0] DEF_TAPS = 16'hB400;

    localparam int DIM_W = 10;

    // Saturate a random box dimension to the last pixel of the tile.
    function automatic logic [DIM_W-1:0] clamp_dim(
        input logic [DIM_W-1:0] v,
        input logic [DIM_W-1:0] lim
    );
        return (v >= lim) ? lim - DIM_W'(1) : v;
    endfunction

endpackage

// File: rtl/tile_pattern_gen_if.sv
// tile_pattern_gen_if: raster position, control and colour
// bundle between the sync source and the pattern generator.
interface tile_pattern_gen_if
    import tile_pattern_pkg::*;
#(
    parameter int COLOR_W = 4
);
    logic               display_en;
    logic [11:0]        h_count;
    logic [11:0]        v_count;
    mode_t              mode;
    logic               reroll;
    logic [COLOR_W-1:0] r_out;
    logic [COLOR_W-1:0] g_out;
    logic [COLOR_W-1:0] b_out;
    logic               frame_tick;
    logic               busy;

    modport master (
        output display_en, h_count, v_count, mode, reroll,
        input  r_out, g_out, b_out, frame_tick, busy
    );

    modport slave (
        input  display_en, h_count, v_count, mode, reroll,
        output r_out, g_out, b_out, frame_tick, busy
    );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: Galois LFSR stepping every clock; a non-zero seed
// with maximal-length taps keeps it out of the all-zero state.
module lfsr_gen
    import tile_pattern_pkg::*;
#(
    parameter int          W     = 16,
    parameter logic [W-1:0] SEED = W'(DEF_SEED),
    parameter logic [W-1:0] TAPS = W'(DEF_TAPS),
    parameter int          OUT_W = 12
) (
    input  logic             clk_in,
    input  logic             reset,
    output logic [OUT_W-1:0] rnd
);
    logic [W-1:0] q;

    // Shift right, folding the taps in when a one drops out.
    always_ff @(posedge clk_in) begin
        if (reset) q <= SEED;
        else       q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    end

    assign rnd = q[OUT_W-1:0];
endmodule

// File: rtl/tile_pattern_gen.sv
// tile_pattern_gen: tiled colour patterns over the active raster;
// random palettes are built in a shadow set, swapped at frame start.
module tile_pattern_gen
    import tile_pattern_pkg::*;
#(
    parameter int               COLOR_W    = 4,
    parameter int               TILE_W     = 100,
    parameter int               TILE_H     = 100,
    parameter int               NUM_COLORS = 4,
    parameter int               LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEF_SEED),
    parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DEF_TAPS)
) (
    input  logic              clk_in,
    input  logic              reset,
    tile_pattern_gen_if.slave bus
);
    localparam int PAL_W = 3 * COLOR_W;
    localparam int IDX_W = $clog2(NUM_COLORS);
    localparam int RND_W = (PAL_W > DIM_W) ? PAL_W : DIM_W;
    localparam int K_W   = IDX_W + 1;

    localparam logic [DIM_W-1:0] TW_M1 = DIM_W'(TILE_W - 1);
    localparam logic [DIM_W-1:0] TH_M1 = DIM_W'(TILE_H - 1);
    localparam logic [K_W-1:0]   K_BOX = K_W'(NUM_COLORS);

    logic             frame_start;
    logic             line_start;
    logic [DIM_W-1:0] tx_q, tx_cur;
    logic [DIM_W-1:0] ty_q, ty_cur;
    logic [11:0]      col_q, col_cur;
    logic [11:0]      row_q, row_cur;
    mode_t            mode_q, mode_cur;

    logic [PAL_W-1:0] act_pal [NUM_COLORS];
    logic [PAL_W-1:0] shd_pal [NUM_COLORS];
    logic [DIM_W-1:0] act_bw, act_bh;
    logic [DIM_W-1:0] shd_bw, shd_bh;
    logic [DIM_W-1:0] bw_cur, bh_cur;

    logic [1:0]       state;
    logic             pending;
    logic [K_W-1:0]   k;
    logic             swap;

    logic [IDX_W-1:0] idx;
    logic [PAL_W-1:0] pix;
    logic [PAL_W-1:0] rgb_q;
    logic             tick_q;
    logic [RND_W-1:0] rnd;

    lfsr_gen #(
        .W     (LFSR_W),
        .SEED  (SEED),
        .TAPS  (TAPS),
        .OUT_W (RND_W)
    ) u_lfsr (
        .clk_in (clk_in),
        .reset  (reset),
        .rnd    (rnd)
    );

    assign line_start  = bus.display_en && (bus.h_count == 12'd0);
    assign frame_start = line_start && (bus.v_count == 12'd0);

    // Tile position of the pixel on the inputs right now.
    always_comb begin
        tx_cur  = line_start ? '0 : tx_q;
        col_cur = line_start ? '0 : col_q;
        ty_cur  = ty_q;
        row_cur = row_q;
        if (frame_start) begin
            ty_cur  = '0;
            row_cur = '0;
        end else if (line_start) begin
            if (ty_q == TH_M1) begin
                ty_cur  = '0;
                row_cur = row_q + 12'd1;
            end else begin
                ty_cur  = ty_q + DIM_W'(1);
            end
        end
    end

    // Step the tile counters past each active pixel.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            tx_q  <= '0;
            ty_q  <= '0;
            col_q <= '0;
            row_q <= '0;
        end else if (bus.display_en) begin
            ty_q  <= ty_cur;
            row_q <= row_cur;
            if (tx_cur == TW_M1) begin
                tx_q  <= '0;
                col_q <= col_cur + 12'd1;
            end else begin
                tx_q  <= tx_cur + DIM_W'(1);
                col_q <= col_cur;
            end
        end
    end

    // Pattern mode is latched once per frame.
    always_ff @(posedge clk_in) begin
        if (reset)            mode_q <= MODE_CHECKER;
        else if (frame_start) mode_q <= bus.mode;
    end

    assign mode_cur = frame_start ? bus.mode : mode_q;
    assign swap     = frame_start && (state == ST_READY);
    assign bw_cur   = swap ? shd_bw : act_bw;
    assign bh_cur   = swap ? shd_bh : act_bh;

    // Palette index for the current pixel.
    always_comb begin
        idx = '0;
        unique case (mode_cur)
            MODE_CHECKER: idx = IDX_W'(col_cur + row_cur);
            MODE_BOX:     idx = ((tx_cur < bw_cur) && (ty_cur < bh_cur))
                                ? IDX_W'(1) : '0;
            MODE_XOR:     idx = IDX_W'(col_cur ^ row_cur);
            MODE_BARS:    idx = IDX_W'(col_cur);
            default:      idx = '0;
        endcase
    end

    assign pix = swap ? shd_pal[idx] : act_pal[idx];

    // Register colour (black in blanking) and the frame pulse.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rgb_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            rgb_q  <= bus.display_en ? pix : '0;
            tick_q <= frame_start;
        end
    end

    // Reroll sequencing: fill shadow, wait for frame start, swap.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
            k       <= '0;
            act_bw  <= DIM_W'(TILE_W / 2);
            act_bh  <= DIM_W'(TILE_H / 2);
            for (int i = 0; i < NUM_COLORS; i++)
                act_pal[i] <= i[0] ? '1 : '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.reroll || pending) begin
                        state   <= ST_FILL;
                        pending <= 1'b0;
                        k       <= '0;
                    end
                end
                ST_FILL: begin
                    if (bus.reroll) pending <= 1'b1;
                    if (k == K_BOX) state <= ST_READY;
                    else            k     <= k + K_W'(1);
                end
                ST_READY: begin
                    if (bus.reroll) pending <= 1'b1;
                    if (frame_start) begin
                        state   <= ST_IDLE;
                        act_pal <= shd_pal;
                        act_bw  <= shd_bw;
                        act_bh  <= shd_bh;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shadow writes: one palette entry per FILL cycle, then box size.
    always_ff @(posedge clk_in) begin
        if (!reset && (state == ST_FILL)) begin
            if (k == K_BOX) begin
                shd_bw <= clamp_dim(rnd[DIM_W-1:0], DIM_W'(TILE_W));
                shd_bh <= clamp_dim(rnd[DIM_W-1:0], DIM_W'(TILE_H));
            end else begin
                shd_pal[k[IDX_W-1:0]] <= rnd[PAL_W-1:0];
            end
        end
    end

    assign bus.r_out      = rgb_q[PAL_W-1 -: COLOR_W];
    assign bus.g_out      = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.b_out      = rgb_q[COLOR_W-1:0];
    assign bus.frame_tick = tick_q;
    assign bus.busy       = pending || (state != ST_IDLE);

endmodule

// File: tb/tb_tile_pattern_gen.sv
// tb_tile_pattern_gen: directed raster sequences with short lines
// standing in for full frames; tile counters only see active pixels.
module tb_tile_pattern_gen;
    import tile_pattern_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tile_pattern_gen_if #(.COLOR_W(4)) bus ();

    tile_pattern_gen #(
        .COLOR_W    (4),
        .TILE_W     (100),
        .TILE_H     (100),
        .NUM_COLORS (4),
        .LFSR_W     (16),
        .SEED       (16'hACE1),
        .TAPS       (16'hB400)
    ) dut (
        .clk_in (clk),
        .reset  (rst),
        .bus    (bus)
    );

    // Reference Galois LFSR x^16+x^14+x^13+x^11+1, seeded 0xACE1.
    logic [15:0] mlf;
    always @(posedge clk) begin
        if (rst) mlf <= 16'hACE1;
        else     mlf <= (mlf >> 1) ^ (mlf[0] ? 16'hB400 : 16'h0000);
    end

    int    n_chk = 0;
    int    n_err = 0;
    mode_t md;
    logic  rr;

    logic [11:0] lo    [512];
    logic        lt    [512];
    logic        lbusy [512];
    logic [15:0] lm    [512];
    logic [11:0] lb;
    logic [11:0] pa [4];
    logic [11:0] qa [4];
    logic [11:0] qb [4];

    task automatic check_eq(input string tag,
                            input logic [11:0] got,
                            input logic [11:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] rgb();
        return {bus.r_out, bus.g_out, bus.b_out};
    endfunction

    task automatic step(input logic de, input int h, input int v);
        @(negedge clk);
        bus.display_en = de;
        bus.h_count    = 12'(h);
        bus.v_count    = 12'(v);
        bus.mode       = md;
        bus.reroll     = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1300, 999);
    endtask

    task automatic line(input int v, input int n);
        for (int h = 0; h < n; h++) begin
            step(1'b1, h, v);
            lo[h]    = rgb();
            lt[h]    = bus.frame_tick;
            lbusy[h] = bus.busy;
            lm[h]    = mlf;
        end
        step(1'b0, n, v);
        lb = rgb();
        step(1'b0, n + 1, v);
    endtask

    initial begin
        rst = 1'b1;
        md  = MODE_CHECKER;
        rr  = 1'b0;
        bus.display_en = 1'b0;
        bus.h_count    = '0;
        bus.v_count    = '0;
        bus.mode       = MODE_CHECKER;
        bus.reroll     = 1'b0;

        repeat (3) step(1'b0, 0, 0);
        check_eq("rst_rgb",  rgb(), 12'h000);
        check_eq("rst_tick", 12'(bus.frame_tick), 12'h0);
        check_eq("rst_busy", 12'(bus.busy), 12'h0);
        rst = 1'b0;
        blank(2);

        // Checkerboard, reset palette (even black, odd white).
        md = MODE_CHECKER;
        line(0, 210);
        check_eq("chk_p0_0",   lo[0],   12'h000);
        check_eq("chk_p99_0",  lo[99],  12'h000);
        check_eq("chk_p100_0", lo[100], 12'hfff);
        check_eq("tick_fs",    12'(lt[0]), 12'h1);
        check_eq("tick_after", 12'(lt[1]), 12'h0);
        check_eq("blank_zero", lb, 12'h000);
        for (int v = 1; v < 100; v++) line(v, 1);
        line(100, 210);
        check_eq("chk_p0_100",   lo[0],   12'hfff);
        check_eq("chk_p100_100", lo[100], 12'h000);
        check_eq("tick_line",    12'(lt[0]), 12'h0);

        // Vertical bars.
        md = MODE_BARS;
        line(0, 410);
        check_eq("bar_h0",   lo[0],   12'h000);
        check_eq("bar_h99",  lo[99],  12'h000);
        check_eq("bar_h100", lo[100], 12'hfff);
        check_eq("bar_h199", lo[199], 12'hfff);
        check_eq("bar_h200", lo[200], 12'h000);
        check_eq("bar_h400", lo[400], 12'h000);

        // Box with reset size 50x50.
        md = MODE_BOX;
        line(0, 160);
        check_eq("box_h49",  lo[49],  12'hfff);
        check_eq("box_h50",  lo[50],  12'h000);
        check_eq("box_h149", lo[149], 12'hfff);
        check_eq("box_h150", lo[150], 12'h000);
        for (int v = 1; v < 49; v++) line(v, 1);
        line(49, 1);
        check_eq("box_ty49", lo[0], 12'hfff);
        line(50, 1);
        check_eq("box_ty50", lo[0], 12'h000);

        // Reroll in blanking; shadow entry j takes the LFSR of cycle j.
        rr = 1'b1;
        step(1'b0, 1300, 50);
        rr = 1'b0;
        check_eq("busy_rr", 12'(bus.busy), 12'h1);
        pa[0] = mlf[11:0];
        for (int j = 1; j < 4; j++) begin
            step(1'b0, 1300, 50);
            pa[j] = mlf[11:0];
        end
        blank(6);
        check_eq("busy_ready", 12'(bus.busy), 12'h1);
        line(60, 1);
        check_eq("pre_swap", lo[0], 12'h000);
        md = MODE_CHECKER;
        line(0, 410);
        check_eq("swap_i0",   lo[0],   pa[0]);
        check_eq("swap_i1",   lo[100], pa[1]);
        check_eq("swap_i2",   lo[200], pa[2]);
        check_eq("swap_i3",   lo[300], pa[3]);
        check_eq("busy_swap", 12'(lbusy[0]), 12'h0);

        // Mode 0 -> 2 at line 300 holds until the next frame.
        md = MODE_CHECKER;
        line(0, 1);
        for (int v = 1; v < 300; v++) line(v, 1);
        md = MODE_XOR;
        line(300, 210);
        check_eq("mid_c0_r3", lo[0],   pa[3]);
        check_eq("mid_c1_r3", lo[100], pa[0]);
        line(0, 1);
        for (int v = 1; v < 100; v++) line(v, 1);
        line(100, 110);
        check_eq("xor_c1_r1", lo[100], pa[0]);
        check_eq("xor_c0_r1", lo[0],   pa[1]);

        // Two extra requests during FILL merge into one more swap.
        rr = 1'b1;
        step(1'b0, 1300, 200);
        rr = 1'b0;
        qa[0] = mlf[11:0];
        step(1'b0, 1300, 200);
        qa[1] = mlf[11:0];
        rr = 1'b1;
        step(1'b0, 1300, 200);
        rr = 1'b0;
        qa[2] = mlf[11:0];
        step(1'b0, 1300, 200);
        qa[3] = mlf[11:0];
        rr = 1'b1;
        step(1'b0, 1300, 200);
        rr = 1'b0;
        blank(6);
        check_eq("busy_pre_f1", 12'(bus.busy), 12'h1);
        md = MODE_BARS;
        line(0, 410);
        check_eq("f1_i0",     lo[0],   qa[0]);
        check_eq("f1_i1",     lo[100], qa[1]);
        check_eq("f1_i2",     lo[200], qa[2]);
        check_eq("f1_i3",     lo[300], qa[3]);
        check_eq("busy_pend", 12'(lbusy[0]), 12'h1);
        for (int j = 0; j < 4; j++) qb[j] = lm[1 + j][11:0];
        blank(8);
        line(0, 410);
        check_eq("f2_i0",   lo[0],   qb[0]);
        check_eq("f2_i1",   lo[100], qb[1]);
        check_eq("f2_i2",   lo[200], qb[2]);
        check_eq("f2_i3",   lo[300], qb[3]);
        check_eq("busy_f2", 12'(lbusy[0]), 12'h0);
        blank(4);
        line(0, 110);
        check_eq("f3_keep", lo[100], qb[1]);
        check_eq("f3_busy", 12'(bus.busy), 12'h0);

        // Reset in the middle of a fill.
        rr = 1'b1;
        step(1'b0, 1300, 0);
        rr = 1'b0;
        step(1'b0, 1300, 0);
        step(1'b0, 1300, 0);
        rst = 1'b1;
        step(1'b0, 1300, 0);
        step(1'b0, 1300, 0);
        rst = 1'b0;
        check_eq("mrst_rgb",  rgb(), 12'h000);
        check_eq("mrst_busy", 12'(bus.busy), 12'h0);
        md = MODE_CHECKER;
        line(0, 110);
        check_eq("mrst_i0",   lo[0],   12'h000);
        check_eq("mrst_i1",   lo[100], 12'hfff);
        check_eq("mrst_noswp", 12'(lbusy[0]), 12'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
